// File: rtl/mdu_hilo.sv
// mdu_hilo: execute-stage multiply/divide unit that owns the HI/LO registers.
// A mult/div result is computed when the operation starts and parked in
// pend_hi/pend_lo. A down-counter then models the multi-cycle latency, and
// HI/LO are written on the final busy edge. mthi/mtlo write in one cycle.
module mdu_hilo #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDU_Ctr,
    input  logic [31:0] E_RS,
    input  logic [31:0] E_RT,
    input  logic        Req,
    output logic        E_Start,
    output logic        E_Busy,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO
);

    // Counter wide enough for the longer latency, never narrower than 4 bits.
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;

    typedef enum logic [3:0] {
        OP_NONE  = 4'b0000,
        OP_MULT  = 4'b0001,
        OP_MULTU = 4'b0010,
        OP_DIV   = 4'b0011,
        OP_DIVU  = 4'b0100,
        OP_MFHI  = 4'b0101,
        OP_MFLO  = 4'b0110,
        OP_MTHI  = 4'b0111,
        OP_MTLO  = 4'b1000
    } mdu_op_e;

    // Architectural and in-flight state
    logic [31:0]      hi;
    logic [31:0]      lo;
    logic [31:0]      pend_hi;
    logic [31:0]      pend_lo;
    logic             pend_wr;   // cleared for a divide by zero: commit leaves HI/LO alone
    logic [CNT_W-1:0] cnt;
    logic             busy;

    // Decoded operation
    logic is_mul;
    logic is_div;
    logic is_signed;
    logic is_mthi;
    logic is_mtlo;
    logic accept;

    // Arithmetic datapath
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] product;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        div_zero;
    logic [31:0] div_den;
    logic [31:0] quo_mag;
    logic [31:0] rem_mag;
    logic [31:0] quotient;
    logic [31:0] remainder;

    // Decode the E-stage control field; unlisted encodings behave as "none"
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        is_mul    = 1'b0;
        is_div    = 1'b0;
        is_signed = 1'b0;
        is_mthi   = 1'b0;
        is_mtlo   = 1'b0;
        case (E_MDU_Ctr)
            OP_MULT:  begin is_mul = 1'b1; is_signed = 1'b1; end
            OP_MULTU: is_mul = 1'b1;
            OP_DIV:   begin is_div = 1'b1; is_signed = 1'b1; end
            OP_DIVU:  is_div = 1'b1;
            OP_MTHI:  is_mthi = 1'b1;
            OP_MTLO:  is_mtlo = 1'b1;
            default:  ;
        endcase
    end

    // An op is taken only when no exception is pending and the unit is idle
    assign accept  = !Req && !busy;
    assign E_Start = accept && (is_mul || is_div);

    // Multiply: extend operands to 64 bits by signedness; the low 64 product bits are exact
    always_comb begin
        mul_a   = is_signed ? {{32{E_RS[31]}}, E_RS} : {32'h0, E_RS};
        mul_b   = is_signed ? {{32{E_RT[31]}}, E_RT} : {32'h0, E_RT};
        product = mul_a * mul_b;
    end

    // Divide via magnitudes: truncation toward zero, remainder follows the
    // dividend; 0x80000000 / -1 wraps to 0x80000000 with remainder 0.
    always_comb begin
        neg_a     = is_signed && E_RS[31];
        neg_b     = is_signed && E_RT[31];
        mag_a     = neg_a ? (~E_RS + 32'd1) : E_RS;
        mag_b     = neg_b ? (~E_RT + 32'd1) : E_RT;
        div_zero  = (E_RT == 32'h0);
        div_den   = div_zero ? 32'd1 : mag_b;
        quo_mag   = mag_a / div_den;
        rem_mag   = mag_a % div_den;
        quotient  = (neg_a ^ neg_b) ? (~quo_mag + 32'd1) : quo_mag;
        remainder = neg_a ? (~rem_mag + 32'd1) : rem_mag;
    end

    // HI/LO, pending result and latency counter
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            hi      <= 32'h0;
            lo      <= 32'h0;
            pend_hi <= 32'h0;
            pend_lo <= 32'h0;
            pend_wr <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
        end else if (busy) begin
            if (cnt == CNT_W'(1)) begin
                if (pend_wr) begin
                    hi <= pend_hi;
                    lo <= pend_lo;
                end
                cnt  <= '0;
                busy <= 1'b0;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end else if (accept) begin
            if (is_mul) begin
                pend_hi <= product[63:32];
                pend_lo <= product[31:0];
                pend_wr <= 1'b1;
                cnt     <= CNT_W'(MULT_CYCLES);
                busy    <= 1'b1;
            end else if (is_div) begin
                pend_hi <= remainder;
                pend_lo <= quotient;
                pend_wr <= !div_zero;
                cnt     <= CNT_W'(DIV_CYCLES);
                busy    <= 1'b1;
            end else if (is_mthi) begin
                hi <= E_RS;
            end else if (is_mtlo) begin
                lo <= E_RS;
            end
        end
    end

    assign E_Busy = busy;
    assign E_HI   = hi;
    assign E_LO   = lo;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed plus randomized checking of mdu_hilo against an
// arithmetic reference model of HI/LO and the busy window.
module tb_mdu_hilo;

    localparam int NM = 5;
    localparam int ND = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  E_MDU_Ctr;
    logic [31:0] E_RS;
    logic [31:0] E_RT;
    logic        Req;
    logic        E_Start;
    logic        E_Busy;
    logic [31:0] E_HI;
    logic [31:0] E_LO;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    logic        m_pwr;
    int          m_left;

    mdu_hilo #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
        .clk       (clk),
        .reset     (reset),
        .E_MDU_Ctr (E_MDU_Ctr),
        .E_RS      (E_RS),
        .E_RT      (E_RT),
        .Req       (Req),
        .E_Start   (E_Start),
        .E_Busy    (E_Busy),
        .E_HI      (E_HI),
        .E_LO      (E_LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Spec-level result of a mult/div: {hi, lo, write_enable}
    task automatic model_result(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                output logic [31:0] rhi, output logic [31:0] rlo, output logic wr);
        longint      ps;
        logic [63:0] pu;
        int          a, b;
        rhi = 32'h0; rlo = 32'h0; wr = 1'b1;
        case (op)
            4'd1: begin
                ps = longint'($signed(rs)) * longint'($signed(rt));
                rhi = ps[63:32]; rlo = ps[31:0];
            end
            4'd2: begin
                pu = 64'(rs) * 64'(rt);
                rhi = pu[63:32]; rlo = pu[31:0];
            end
            4'd3: begin
                a = rs; b = rt;
                if (rt == 0) wr = 1'b0;
                else if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) begin
                    rlo = 32'h8000_0000; rhi = 32'h0;
                end else begin
                    rlo = a / b; rhi = a % b;
                end
            end
            default: begin
                if (rt == 0) wr = 1'b0;
                else begin
                    rlo = rs / rt; rhi = rs % rt;
                end
            end
        endcase
    endtask

    // Advance the model by one clock edge with the given inputs
    task automatic model_edge(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                              input logic rq, input logic rst);
        if (rst) begin
            m_hi = 0; m_lo = 0; m_left = 0; m_pwr = 0;
        end else if (m_left > 0) begin
            if (m_left == 1 && m_pwr) begin
                m_hi = m_phi; m_lo = m_plo;
            end
            m_left--;
        end else if (!rq) begin
            if (op >= 4'd1 && op <= 4'd4) begin
                model_result(op, rs, rt, m_phi, m_plo, m_pwr);
                m_left = (op <= 4'd2) ? NM : ND;
            end else if (op == 4'd7) m_hi = rs;
            else if (op == 4'd8) m_lo = rs;
        end
    endtask

    // One clock cycle: drive at negedge, check E_Start, then check state after the edge
    task automatic step(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic rq, input logic rst);
        logic exp_start;
        @(negedge clk);
        reset = rst; E_MDU_Ctr = op; E_RS = rs; E_RT = rt; Req = rq;
        #1;
        exp_start = (op >= 4'd1 && op <= 4'd4) && !rq && (m_left == 0);
        check("start", {31'b0, E_Start}, {31'b0, exp_start});
        @(posedge clk);
        model_edge(op, rs, rt, rq, rst);
        #1;
        check("busy", {31'b0, E_Busy}, {31'b0, (m_left != 0)});
        check("hi", E_HI, m_hi);
        check("lo", E_LO, m_lo);
        reset = 1'b0; E_MDU_Ctr = 4'd0; E_RS = 32'h0; E_RT = 32'h0; Req = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            4: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [3:0]  op;
        logic [31:0] rs, rt;
        reset = 1'b1; E_MDU_Ctr = 4'd0; E_RS = 32'h0; E_RT = 32'h0; Req = 1'b0;
        m_hi = 'x; m_lo = 'x; m_phi = 0; m_plo = 0; m_pwr = 0; m_left = 0;

        // Reset state
        step(4'd0, 32'h0, 32'h0, 1'b0, 1'b1);
        check("rst_hi", E_HI, 32'h0);
        check("rst_lo", E_LO, 32'h0);

        // mult -1 * 2
        step(4'd1, 32'hFFFF_FFFF, 32'h2, 1'b0, 1'b0);
        check("mult_busy_T1", {31'b0, E_Busy}, 32'd1);
        idle(NM);
        check("mult_hi", E_HI, 32'hFFFF_FFFF);
        check("mult_lo", E_LO, 32'hFFFF_FFFE);
        check("mult_idle", {31'b0, E_Busy}, 32'd0);

        // multu same operands
        step(4'd2, 32'hFFFF_FFFF, 32'h2, 1'b0, 1'b0);
        idle(NM);
        check("multu_hi", E_HI, 32'h0000_0001);
        check("multu_lo", E_LO, 32'hFFFF_FFFE);

        // div -7 / 2 and divu 7 / 2
        step(4'd3, 32'hFFFF_FFF9, 32'h2, 1'b0, 1'b0);
        idle(ND);
        check("div_lo", E_LO, 32'hFFFF_FFFD);
        check("div_hi", E_HI, 32'hFFFF_FFFF);
        step(4'd4, 32'h7, 32'h2, 1'b0, 1'b0);
        idle(ND);
        check("divu_lo", E_LO, 32'h3);
        check("divu_hi", E_HI, 32'h1);

        // Overflow case of signed divide
        step(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        idle(ND);
        check("ovf_lo", E_LO, 32'h8000_0000);
        check("ovf_hi", E_HI, 32'h0);

        // mthi then mtlo back to back, then divide by zero
        step(4'd7, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
        check("mthi", E_HI, 32'h1234_5678);
        step(4'd8, 32'h9ABC_DEF0, 32'h0, 1'b0, 1'b0);
        check("mtlo", E_LO, 32'h9ABC_DEF0);
        step(4'd3, 32'h55, 32'h0, 1'b0, 1'b0);
        idle(ND);
        check("div0_hi", E_HI, 32'h1234_5678);
        check("div0_lo", E_LO, 32'h9ABC_DEF0);

        // Req blocks a start; Req during RUN does not abort
        step(4'd1, 32'h3, 32'h4, 1'b1, 1'b0);
        check("req_block_busy", {31'b0, E_Busy}, 32'd0);
        check("req_block_lo", E_LO, 32'h9ABC_DEF0);
        step(4'd1, 32'h3, 32'h4, 1'b0, 1'b0);
        idle(1);
        step(4'd0, 32'h0, 32'h0, 1'b1, 1'b0);
        idle(NM - 2);
        check("req_run_lo", E_LO, 32'd12);
        check("req_run_hi", E_HI, 32'd0);

        // mtlo while busy is ignored; op on the commit cycle is ignored
        step(4'd1, 32'h2, 32'h2, 1'b0, 1'b0);
        step(4'd8, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
        idle(NM - 2);
        step(4'd7, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0);
        check("busy_mtlo_lo", E_LO, 32'd4);
        check("commit_mthi_hi", E_HI, 32'd0);

        // Reset mid-divide
        step(4'd3, 32'h64, 32'h3, 1'b0, 1'b0);
        idle(3);
        step(4'd0, 32'h0, 32'h0, 1'b0, 1'b1);
        check("rst_mid_busy", {31'b0, E_Busy}, 32'd0);
        check("rst_mid_hi", E_HI, 32'h0);
        check("rst_mid_lo", E_LO, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            op = 4'($urandom_range(0, 10));
            rs = pick_val();
            rt = pick_val();
            step(op, rs, rt, ($urandom_range(0, 7) == 0), ($urandom_range(0, 99) == 0));
        end
        idle(ND + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
